// File: rtl/dcp_status_printer.sv
// dcp_status_printer
//   Snapshots NCH data words on a start pulse and streams them as one ASCII
//   line over a byte-wide valid/ready transmit port.
//   Each enabled channel is sent as "LABEL=HEX ". The line ends with CR LF.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           print request, accepted only while idle
//   busy            high while a line is being emitted
//   finish          one-cycle pulse after the LF byte has been taken
//   data            channel words, channel i at data[i*DW +: DW]
//   labels          label characters, channel i at labels[i*LW*8 +: LW*8];
//                   the MSB byte comes first, and 0x00 bytes are skipped
//   chan_mask       per-channel print enable
//   rdy_tx          transmitter ready
//   vld_tx, d_tx    byte being offered to the transmitter
module dcp_status_printer #(
    parameter int NCH = 9,
    parameter int DW  = 32,
    parameter int LW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                finish,
    input  logic [NCH*DW-1:0]   data,
    input  logic [NCH*LW*8-1:0] labels,
    input  logic [NCH-1:0]      chan_mask,
    input  logic                rdy_tx,
    output logic                vld_tx,
    output logic [7:0]          d_tx
);
    localparam int NDIG = DW / 4;
    localparam int CW   = $clog2(NCH) + 1;
    localparam int LIW  = (LW > 1) ? $clog2(LW) : 1;
    localparam int DIW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LABEL, S_EQ, S_HEX, S_SEP, S_CR, S_LF, S_DONE
    } state_t;

    // The registers below always describe the byte currently held in d_tx.
    state_t             state_reg;
    logic [CW-1:0]      ch_reg;
    logic [LIW-1:0]     ci_reg;
    logic [DIW-1:0]     di_reg;
    logic [7:0]         d_tx_reg;
    logic               vld_reg, busy_reg, finish_reg;
    logic [NCH*DW-1:0]  data_snap_reg;
    logic [NCH*LW*8-1:0] labels_snap_reg;
    logic [NCH-1:0]     mask_snap_reg;

    // While idle the first byte comes from the live inputs, because the
    // snapshot is loaded on the same edge. After that the snapshot is used.
    logic               use_live;
    logic [NCH*DW-1:0]  src_data;
    logic [NCH*LW*8-1:0] src_labels;
    logic [NCH-1:0]     src_mask;
    logic [7:0]         src_lab [NCH][LW];
    logic [DW-1:0]      src_dat [NCH];

    assign use_live   = (state_reg == S_IDLE);
    assign src_data   = use_live ? data      : data_snap_reg;
    assign src_labels = use_live ? labels    : labels_snap_reg;
    assign src_mask   = use_live ? chan_mask : mask_snap_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign src_dat[gi] = src_data[gi*DW +: DW];
            for (genvar gj = 0; gj < LW; gj++) begin : g_lab
                assign src_lab[gi][gj] = src_labels[gi*LW*8 + (LW-1-gj)*8 +: 8];
            end
        end
    endgenerate

    logic [CW-1:0]  ch_from, ch_sel, nch;
    logic           ch_found, ent_found, cont_found;
    logic [LIW-1:0] ent_ci, cont_ci, nci;
    logic [DIW-1:0] ndi;
    state_t         nstate;
    logic [7:0]     sel_lab, byte_next;
    logic [DW-1:0]  sel_dat;
    logic [3:0]     nib;
    logic           adv;

    // Find the next position to emit. Disabled channels and zero label bytes
    // are skipped within a single cycle by searching ahead.
    always_comb begin
        ch_from  = use_live ? '0 : ch_reg + 1'b1;
        ch_found = 1'b0;
        ch_sel   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!ch_found && c >= int'(ch_from) && src_mask[c]) begin
                ch_found = 1'b1;
                ch_sel   = CW'(c);
            end
        end

        // first non-zero label byte of the channel being entered
        ent_found = 1'b0;
        ent_ci    = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < LW; p++) begin
                if (c == int'(ch_sel) && !ent_found && src_lab[c][p] != 8'h00) begin
                    ent_found = 1'b1;
                    ent_ci    = LIW'(p);
                end
            end
        end

        // next non-zero label byte after the current one
        cont_found = 1'b0;
        cont_ci    = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < LW; p++) begin
                if (c == int'(ch_reg) && p > int'(ci_reg) && !cont_found &&
                    src_lab[c][p] != 8'h00) begin
                    cont_found = 1'b1;
                    cont_ci    = LIW'(p);
                end
            end
        end

        nstate = state_reg;
        nch    = ch_reg;
        nci    = ci_reg;
        ndi    = di_reg;
        case (state_reg)
            S_IDLE, S_SEP: begin
                if (ch_found) begin
                    nch    = ch_sel;
                    nci    = ent_ci;
                    ndi    = '0;
                    nstate = ent_found ? S_LABEL : S_EQ;
                end else begin
                    nstate = S_CR;
                end
            end
            S_LABEL: begin
                if (cont_found) nci    = cont_ci;
                else            nstate = S_EQ;
            end
            S_EQ: begin
                nstate = S_HEX;
                ndi    = '0;
            end
            S_HEX: begin
                if (int'(di_reg) == NDIG - 1) nstate = S_SEP;
                else                          ndi    = di_reg + 1'b1;
            end
            S_CR:    nstate = S_LF;
            S_LF:    nstate = S_DONE;
            default: nstate = S_IDLE;
        endcase

        // byte for the chosen position
        sel_lab = '0;
        sel_dat = '0;
        for (int c = 0; c < NCH; c++) begin
            if (c == int'(nch)) begin
                sel_dat = src_dat[c];
                for (int p = 0; p < LW; p++) begin
                    if (p == int'(nci)) sel_lab = src_lab[c][p];
                end
            end
        end
        nib = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (k == int'(ndi)) nib = sel_dat[(NDIG-1-k)*4 +: 4];
        end

        case (nstate)
            S_LABEL: byte_next = sel_lab;
            S_EQ:    byte_next = 8'h3D;
            S_HEX:   byte_next = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                               : (8'h37 + {4'h0, nib});
            S_SEP:   byte_next = 8'h20;
            S_CR:    byte_next = 8'h0D;
            S_LF:    byte_next = 8'h0A;
            default: byte_next = 8'h00;
        endcase

        adv = (state_reg == S_IDLE && start) || (vld_reg && rdy_tx) ||
              (state_reg == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ch_reg     <= '0;
            ci_reg     <= '0;
            di_reg     <= '0;
            d_tx_reg   <= 8'h00;
            vld_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            finish_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                data_snap_reg   <= data;
                labels_snap_reg <= labels;
                mask_snap_reg   <= chan_mask;
            end
            if (adv) begin
                state_reg  <= nstate;
                ch_reg     <= nch;
                ci_reg     <= nci;
                di_reg     <= ndi;
                d_tx_reg   <= byte_next;
                vld_reg    <= (nstate != S_IDLE) && (nstate != S_DONE);
                busy_reg   <= (nstate != S_IDLE) && (nstate != S_DONE);
                finish_reg <= (nstate == S_DONE);
            end
        end
    end

    assign busy   = busy_reg;
    assign finish = finish_reg;
    assign vld_tx = vld_reg;
    assign d_tx   = d_tx_reg;

endmodule
